// File: rtl/debounce_sync.sv
// debounce_sync: synchroniser + stability-counter debouncer with rise pulse and optional fall pulse (DEBOUNCE_FALL_PULSE_EN)
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic d_clean,
  output logic rise_pulse,
`ifdef DEBOUNCE_FALL_PULSE_EN
  output logic fall_pulse,
`endif
  output logic busy
);
  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic d_clean_q, d_clean_d, rise_q, rise_d, busy_q, busy_d;
  logic s, lvl, waiting, chg, flip;
`ifdef DEBOUNCE_FALL_PULSE_EN
  logic fall_q, fall_d;
`endif
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], btn_in};
    s         = sync_q[SYNC_STAGES-1];
    lvl       = (state_q == IDLE_HIGH) || (state_q == WAIT_LOW);
    waiting   = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);
    chg       = s != lvl;
    flip      = chg && (waiting ? (cnt_q == LAST) : (STABLE_CYCLES == 1));
    state_d   = flip ? (lvl ? IDLE_LOW : IDLE_HIGH) :
                chg  ? (lvl ? WAIT_LOW : WAIT_HIGH) :
                       (lvl ? IDLE_HIGH : IDLE_LOW);
    cnt_d     = (flip || !chg) ? '0 : cnt_q + CNT_W'(1);
    d_clean_d = flip ? !lvl : lvl;
    rise_d    = flip && !lvl;
    busy_d    = chg && !flip;
`ifdef DEBOUNCE_FALL_PULSE_EN
    fall_d    = flip && lvl;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE_LOW;
      sync_q    <= '0;
      cnt_q     <= '0;
      d_clean_q <= 1'b0;
      rise_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
      fall_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      d_clean_q <= d_clean_d;
      rise_q    <= rise_d;
      busy_q    <= busy_d;
`ifdef DEBOUNCE_FALL_PULSE_EN
      fall_q    <= fall_d;
`endif
    end
  end
  assign d_clean    = d_clean_q;
  assign rise_pulse = rise_q;
  assign busy       = busy_q;
`ifdef DEBOUNCE_FALL_PULSE_EN
  assign fall_pulse = fall_q;
`endif
endmodule
